// File: rtl/parking_slot_allocator.sv
// Parking slot allocator: scans the free-slot bitmap, grants one-hot slots and takes exit releases back.
// Optional macro PARK_ROUND_ROBIN_EN starts each scan after the last granted slot instead of at slot 0.
module parking_slot_allocator #(
  parameter int NUM_SLOTS = 8,
  parameter int IDX_W     = 3,
  parameter int CNT_W     = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 entry_req,
  output logic                 grant_valid,
  input  logic                 grant_ready,
  output logic [NUM_SLOTS-1:0] park_location,
  output logic [IDX_W-1:0]     slot_index,
  output logic                 entry_reject,
  input  logic                 exit_valid,
  input  logic [NUM_SLOTS-1:0] exit_location,
  output logic                 release_err,
  output logic [NUM_SLOTS-1:0] free_slots,
  output logic [CNT_W-1:0]     free_count,
  output logic                 full
);

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_GRANT} state_e;

  state_e               state_q, state_d;
  logic [IDX_W-1:0]     ptr_q, ptr_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [NUM_SLOTS-1:0] free_q, free_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 rej_q, rej_d;
  logic                 rerr_q, rerr_d;
  logic [NUM_SLOTS-1:0] alloc_mask, rel_mask;
  logic                 rel_ok;
  logic [IDX_W-1:0]     start_slot;

`ifdef PARK_ROUND_ROBIN_EN
  logic [IDX_W-1:0]     last_q, last_d;

  assign start_slot = (last_q == IDX_W'(NUM_SLOTS-1)) ? '0 : last_q + 1'b1;
`else
  assign start_slot = '0;
`endif

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    idx_d      = idx_q;
    rej_d      = 1'b0;
    alloc_mask = '0;
`ifdef PARK_ROUND_ROBIN_EN
    last_d     = last_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (entry_req) begin
          if (full) begin
            rej_d = 1'b1;
          end else begin
            state_d = S_SCAN;
            ptr_d   = start_slot;
          end
        end
      end
      S_SCAN: begin
        if (free_q[ptr_q]) begin
          alloc_mask[ptr_q] = 1'b1;
          idx_d             = ptr_q;
          state_d           = S_GRANT;
`ifdef PARK_ROUND_ROBIN_EN
          last_d            = ptr_q;
`endif
        end else begin
          ptr_d = (ptr_q == IDX_W'(NUM_SLOTS-1)) ? '0 : ptr_q + 1'b1;
        end
      end
      S_GRANT: begin
        if (grant_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Release legality is judged against the current bitmap, so releasing the slot
    // being allocated this same cycle is an error (it is still free in free_q).
    rel_ok   = exit_valid && $onehot(exit_location) && ((exit_location & free_q) == '0);
    rel_mask = rel_ok ? exit_location : '0;
    rerr_d   = exit_valid && !rel_ok;

    free_d = (free_q & ~alloc_mask) | rel_mask;
    cnt_d  = '0;
    for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
      cnt_d = cnt_d + CNT_W'(free_d[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      idx_q   <= '0;
      free_q  <= '1;
      cnt_q   <= CNT_W'(NUM_SLOTS);
      rej_q   <= 1'b0;
      rerr_q  <= 1'b0;
`ifdef PARK_ROUND_ROBIN_EN
      last_q  <= IDX_W'(NUM_SLOTS-1);
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      free_q  <= free_d;
      cnt_q   <= cnt_d;
      rej_q   <= rej_d;
      rerr_q  <= rerr_d;
`ifdef PARK_ROUND_ROBIN_EN
      last_q  <= last_d;
`endif
    end
  end

  assign grant_valid   = (state_q == S_GRANT);
  assign park_location = grant_valid ? (NUM_SLOTS'(1) << idx_q) : '0;
  assign slot_index    = idx_q;
  assign entry_reject  = rej_q;
  assign release_err   = rerr_q;
  assign free_slots    = free_q;
  assign free_count    = cnt_q;
  assign full          = (cnt_q == '0);

endmodule

// File: tb/tb_parking_slot_allocator.sv
// Randomized self-checking bench for parking_slot_allocator against a slot-array reference model.
module tb_parking_slot_allocator;

  localparam int N = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         entry_req = 1'b0;
  logic         grant_valid;
  logic         grant_ready = 1'b0;
  logic [N-1:0] park_location;
  logic [2:0]   slot_index;
  logic         entry_reject;
  logic         exit_valid = 1'b0;
  logic [N-1:0] exit_location = '0;
  logic         release_err;
  logic [N-1:0] free_slots;
  logic [3:0]   free_count;
  logic         full;

  parking_slot_allocator #(.NUM_SLOTS(8), .IDX_W(3), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .entry_req(entry_req), .grant_valid(grant_valid),
    .grant_ready(grant_ready), .park_location(park_location), .slot_index(slot_index),
    .entry_reject(entry_reject), .exit_valid(exit_valid), .exit_location(exit_location),
    .release_err(release_err), .free_slots(free_slots), .free_count(free_count), .full(full)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: phase 0 = waiting, 1 = searching, 2 = holding a grant.
  bit m_free[N];
  int m_phase, m_ptr, m_gidx, m_last;
  bit m_rej, m_rerr;

  function automatic int m_count();
    int c = 0;
    for (int i = 0; i < N; i++) c += m_free[i];
    return c;
  endfunction

  function automatic logic [N-1:0] m_bitmap();
    logic [N-1:0] b;
    for (int i = 0; i < N; i++) b[i] = m_free[i];
    return b;
  endfunction

  task automatic model_step();
    int alloc = -1;
    int pos = 0;
    bit ok;
    if (rst) begin
      for (int i = 0; i < N; i++) m_free[i] = 1'b1;
      m_phase = 0; m_ptr = 0; m_gidx = 0; m_last = N - 1; m_rej = 0; m_rerr = 0;
      return;
    end
    m_rej = 0;
    case (m_phase)
      0: if (entry_req) begin
           if (m_count() == 0) m_rej = 1;
           else begin
             m_phase = 1;
`ifdef PARK_ROUND_ROBIN_EN
             m_ptr = (m_last + 1) % N;
`else
             m_ptr = 0;
`endif
           end
         end
      1: if (m_free[m_ptr]) begin
           alloc = m_ptr; m_gidx = m_ptr; m_last = m_ptr; m_phase = 2;
         end else m_ptr = (m_ptr + 1) % N;
      default: if (grant_ready) m_phase = 0;
    endcase
    for (int i = 0; i < N; i++) if (exit_location[i]) pos = i;
    ok = exit_valid && ($countones(exit_location) == 1) && !m_free[pos];
    m_rerr = exit_valid && !ok;
    if (alloc >= 0) m_free[alloc] = 1'b0;
    if (ok) m_free[pos] = 1'b1;
  endtask

  task automatic compare_all();
    logic [N-1:0] exp_loc;
    logic [N-1:0] one = 1;
    exp_loc = (m_phase == 2) ? (one << m_gidx) : '0;
    check_eq("grant_valid", grant_valid, (m_phase == 2));
    check_eq("park_location", park_location, exp_loc);
    if (m_phase == 2) check_eq("slot_index", slot_index, m_gidx);
    check_eq("entry_reject", entry_reject, m_rej);
    check_eq("release_err", release_err, m_rerr);
    check_eq("free_slots", free_slots, m_bitmap());
    check_eq("free_count", free_count, m_count());
    check_eq("full", full, (m_count() == 0));
  endtask

  task automatic tick(input bit r, input bit req, input bit rdy, input bit ev, input logic [N-1:0] loc);
    @(negedge clk);
    rst = r; entry_req = req; grant_ready = rdy; exit_valid = ev; exit_location = loc;
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  initial begin
    logic [N-1:0] loc;
    int budget;
    tick(1, 0, 0, 0, '0);
    tick(1, 0, 0, 0, '0);
    check_eq("rst_free", free_slots, 8'hFF);
    check_eq("rst_count", free_count, 4'd8);

    // single request: grant appears two edges after the request edge
    tick(0, 1, 1, 0, '0);
    tick(0, 0, 1, 0, '0);
    check_eq("t1_valid", grant_valid, 1'b1);
    check_eq("t1_loc", park_location, 8'h01);
    check_eq("t1_free", free_slots, 8'hFE);
    check_eq("t1_count", free_count, 4'd7);
    tick(0, 0, 1, 0, '0);

    // fill the lot, then keep requesting to see rejects
    budget = 0;
    while (free_count != 0 && budget < 100) begin
      tick(0, 1, 1, 0, '0);
      budget++;
    end
    check_eq("t2_full_reached", (budget < 100), 1'b1);
    for (int i = 0; i < 4; i++) tick(0, 1, 1, 0, '0);
    check_eq("t2_reject", entry_reject, 1'b1);

    // illegal releases: two-hot, zero, then a legal one and its duplicate
    tick(0, 0, 1, 1, 8'h06);
    check_eq("t4_err_twohot", release_err, 1'b1);
    tick(0, 0, 1, 1, 8'h00);
    tick(0, 0, 1, 1, 8'h80);
    tick(0, 0, 1, 1, 8'h80);
    check_eq("t4_err_dup", release_err, 1'b1);

    // slot 7 only free: wait for grant, hold it, then reset mid-grant
    tick(0, 1, 0, 0, '0);
    budget = 0;
    while (!grant_valid && budget < 20) begin
      tick(0, 0, 0, 0, '0);
      budget++;
    end
    check_eq("t3_grant_loc", park_location, 8'h80);
    tick(0, 0, 0, 0, '0);
    tick(1, 0, 0, 0, '0);
    check_eq("t6_valid", grant_valid, 1'b0);
    check_eq("t6_free", free_slots, 8'hFF);

    // randomized traffic
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 9) < 7) loc = N'(1) << $urandom_range(0, N - 1);
      else loc = N'($urandom);
      tick(($urandom_range(0, 199) == 0), ($urandom_range(0, 1) == 1),
           ($urandom_range(0, 9) < 6), ($urandom_range(0, 9) < 3), loc);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
